// File: rtl/dma_pkg.sv
// Shared types for the multi-channel DMA engine: controller states and channel transfer modes.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    typedef enum logic {
        MODE_COPY  = 1'b0,
        MODE_FETCH = 1'b1
    } dma_mode_t;

endpackage

// File: rtl/dma_channel_regs.sv
// Per-channel request state: start edge detect, latched transfer parameters,
// byte index counter and busy/last flags.
module dma_channel_regs
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              mode_in,
    input  logic              step,
    output logic              busy,
    output logic              last,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] dst,
    output dma_mode_t         mode
);

    logic              start_prev;
    logic              trigger;
    logic [ADDR_W-1:0] src;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  index;

    // A retrigger while busy (including the completion cycle) is ignored.
    assign trigger = en & start & ~start_prev & ~busy;
    assign last    = (index == len_q);
    assign rd_addr = src + ADDR_W'(index);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_prev <= 1'b0;
            busy       <= 1'b0;
            src        <= '0;
            dst        <= '0;
            len_q      <= '0;
            index      <= '0;
            mode       <= MODE_COPY;
        end else if (en) begin
            start_prev <= start;
            if (trigger) begin
                src   <= src_in;
                dst   <= dst_in;
                len_q <= len_in;
                mode  <= dma_mode_t'(mode_in);
                index <= '0;
                busy  <= 1'b1;
            end else if (step) begin
                if (last) begin
                    busy <= 1'b0;
                end else begin
                    index <= index + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_dma_controller.sv
// Multi-channel DMA engine: fixed-priority channels (ch0 highest) share one bus,
// copying (read then write) or fetching (read only) bytes on get/put aligned cycles.
module multi_dma_controller
    import dma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_en,
    input  logic                     stop,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH*ADDR_W-1:0] src_addr,
    input  logic [NUM_CH*ADDR_W-1:0] dst_addr,
    input  logic [NUM_CH*LEN_W-1:0]  len,
    input  logic [NUM_CH-1:0]        mode,
    input  logic [7:0]               rdata,
    output logic                     dma,
    output logic [ADDR_W-1:0]        addr,
    output logic                     read,
    output logic                     write,
    output logic [7:0]               wdata,
    output logic                     fetch_vld,
    output logic [7:0]               fetch_data,
    output logic [CH_W-1:0]          fetch_ch,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done
);

    logic              en;
    dma_state_t        state, state_nxt;
    logic              phase;
    logic              arb;
    logic              any_avail;
    logic              byte_done;
    logic [CH_W-1:0]   cur_ch, next_ch;
    logic [7:0]        byte_p1;
    logic              fetch_vld_p1;
    logic [CH_W-1:0]   fetch_ch_p1;
    logic [NUM_CH-1:0] busy_vec, last_vec, step_vec, done_vec;
    logic [ADDR_W-1:0] ch_rd_addr [NUM_CH];
    logic [ADDR_W-1:0] ch_dst     [NUM_CH];
    dma_mode_t         ch_mode    [NUM_CH];
    dma_mode_t         cur_mode;

    assign en       = cpu_en & ~stop;
    assign cur_mode = ch_mode[cur_ch];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dma_channel_regs #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_regs (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .start   (start[g]),
            .src_in  (src_addr[g*ADDR_W +: ADDR_W]),
            .dst_in  (dst_addr[g*ADDR_W +: ADDR_W]),
            .len_in  (len[g*LEN_W +: LEN_W]),
            .mode_in (mode[g]),
            .step    (step_vec[g]),
            .busy    (busy_vec[g]),
            .last    (last_vec[g]),
            .rd_addr (ch_rd_addr[g]),
            .dst     (ch_dst[g]),
            .mode    (ch_mode[g])
        );
    end

    // A byte completes on its WRITE (copy) or on its READ (fetch).
    assign byte_done = en & ((state == WRITE) | ((state == READ) & (cur_mode == MODE_FETCH)));
    assign done_vec  = step_vec & last_vec;

    // A channel finishing this cycle is no longer a candidate at the arbitration point.
    always_comb begin
        step_vec  = '0;
        any_avail = 1'b0;
        next_ch   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            step_vec[i] = byte_done && (cur_ch == CH_W'(i));
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (busy_vec[i] && !(step_vec[i] && last_vec[i])) begin
                any_avail = 1'b1;
                next_ch   = CH_W'(i);
            end
        end
    end

    // READ is only launched from a phase-0 cycle; otherwise spend one ALIGN cycle.
    always_comb begin
        state_nxt = state;
        arb       = 1'b0;
        case (state)
            IDLE:        if (|busy_vec) state_nxt = HALT;
            HALT, ALIGN: arb = 1'b1;
            READ:        if (cur_mode == MODE_COPY) state_nxt = WRITE; else arb = 1'b1;
            WRITE:       arb = 1'b1;
            default:     state_nxt = IDLE;
        endcase
        if (arb) begin
            if (!any_avail) begin
                state_nxt = IDLE;
            end else if (phase) begin
                state_nxt = ALIGN;
            end else begin
                state_nxt = READ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            phase  <= 1'b0;
            cur_ch <= '0;
        end else if (en) begin
            state <= state_nxt;
            phase <= ~phase;
            if (arb && any_avail) begin
                cur_ch <= next_ch;
            end
        end
    end

    // Stage p1: byte captured in READ, presented as write data or fetch result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_p1      <= '0;
            fetch_vld_p1 <= 1'b0;
            fetch_ch_p1  <= '0;
        end else if (en) begin
            fetch_vld_p1 <= (state == READ) && (cur_mode == MODE_FETCH);
            if (state == READ) begin
                byte_p1     <= rdata;
                fetch_ch_p1 <= cur_ch;
            end
        end
    end

    always_comb begin
        case (state)
            READ:    addr = ch_rd_addr[cur_ch];
            WRITE:   addr = ch_dst[cur_ch];
            default: addr = '0;
        endcase
    end

    assign dma        = (state != IDLE);
    assign read       = en & (state == READ);
    assign write      = en & (state == WRITE);
    assign wdata      = byte_p1;
    assign fetch_data = byte_p1;
    assign fetch_vld  = en & fetch_vld_p1;
    assign fetch_ch   = fetch_ch_p1;
    assign busy       = busy_vec;
    assign done       = done_vec;

endmodule
